// File: rtl/cache_def_pkg.sv
// Shared types for the memory responder that backs the cache controller.
//   mem_req_type  : request from the cache controller (addr, line data, rw, valid)
//   mem_data_type : response to the cache controller (line data, ready pulse)
//   mem_state_e   : responder FSM states
//   MEM_LATENCY_DEF / MEM_DEPTH_DEF : default build parameters
package cache_def;

  localparam int unsigned MEM_LATENCY_DEF = 4;
  localparam int unsigned MEM_DEPTH_DEF   = 256;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;     // 1 = write line, 0 = read line
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } mem_state_e;

endpackage

// File: rtl/mem_line_ram.sv
// Line storage for the memory responder: MEM_DEPTH lines of 128 bits,
// single port, synchronous write, asynchronous read, no reset.
//   clk_i   : clock
//   we      : write enable, line written at the rising edge
//   idx     : line index shared by read and write
//   wdata   : line data to write
//   rdata   : line contents at idx (combinational)
module mem_line_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic               clk_i,
  input  logic               we,
  input  logic [IDX_W-1:0]   idx,
  input  logic [127:0]       wdata,
  output logic [127:0]       rdata
);

  logic [127:0] mem [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory model answering cache controller requests.
// A request accepted at one rising edge produces a one-cycle ready pulse
// MEM_LATENCY edges later; reads return the line combinationally during
// that cycle, writes commit at its end. A new request may be accepted in
// the response cycle so write-back followed by allocate runs back to back.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset (line storage is kept)
//   mem_req_i  : request (sampled only on the accept edge)
//   mem_data_o : response data and ready pulse (data is 0 unless reading)
//   busy_o     : a request is in flight
//   no_rd_o    : completed read count
//   no_wr_o    : completed write count
// Build option: define MEM_STATS_EN to implement the read/write counters;
// otherwise both counter outputs are tied to 0.
module mem_responder
  import cache_def::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mem_req_type  mem_req_i,
  output mem_data_type mem_data_o,
  output logic         busy_o,
  output logic [31:0]  no_rd_o,
  output logic [31:0]  no_wr_o
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  mem_state_e   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         accept;
  logic [31:0]  addr_q;
  logic [127:0] data_q;
  logic         rw_q;
  logic         resp;
  logic         ram_we;
  logic [127:0] ram_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: accept = mem_req_i.valid;
      ST_BUSY: begin
        if (cnt_q == 8'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_RESP: begin
        accept = mem_req_i.valid;
        if (!mem_req_i.valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_BUSY;
      cnt_d   = 8'(MEM_LATENCY - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      rw_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= mem_req_i.addr;
      data_q <= mem_req_i.data;
      rw_q   <= mem_req_i.rw;
    end
  end

  assign resp   = (state_q == ST_RESP);
  // A reset landing on the response edge aborts the write as well.
  assign ram_we = resp && rw_q && rst_ni;

  mem_line_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .idx   (addr_q[IDX_W+3:4]),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  // Offset bits and bits above the index alias onto the same line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[31:IDX_W+4], addr_q[3:0]};

  assign mem_data_o.ready = resp;
  assign mem_data_o.data  = (resp && !rw_q) ? ram_rdata : '0;
  assign busy_o           = (state_q != ST_IDLE);

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (resp) begin
      if (rw_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign no_rd_o = rd_cnt_q;
  assign no_wr_o = wr_cnt_q;
`else
  assign no_rd_o = '0;
  assign no_wr_o = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance at default latency and
// one at MEM_LATENCY=1. Expected responses are queued at request time with
// the cycle they must appear in and popped by per-instance monitors.
module tb_mem_responder;
  import cache_def::*;

  logic         clk = 1'b0;
  logic         rst_ni0, rst_ni1;
  mem_req_type  req0, req1;
  mem_data_type rsp0, rsp1;
  logic         busy0, busy1;
  logic [31:0]  no_rd0, no_wr0, no_rd1, no_wr1;

  always #5 clk = ~clk;

  mem_responder dut0 (
    .clk_i(clk), .rst_ni(rst_ni0), .mem_req_i(req0), .mem_data_o(rsp0),
    .busy_o(busy0), .no_rd_o(no_rd0), .no_wr_o(no_wr0)
  );

  mem_responder #(.MEM_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni1), .mem_req_i(req1), .mem_data_o(rsp1),
    .busy_o(busy1), .no_rd_o(no_rd1), .no_wr_o(no_wr1)
  );

  typedef struct {
    int           cyc;
    logic [127:0] data;
    bit           rw;
  } exp_t;

  exp_t         q0[$], q1[$];
  logic [127:0] model0 [256];
  logic [127:0] model1 [256];
  int           cyc = 0;
  int           checks = 0, failures = 0;
  int           exp_rd0 = 0, exp_wr0 = 0, exp_rd1 = 0, exp_wr1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Monitors: a response must appear exactly in the queued cycle, and
  // ready/data must stay 0 in every other cycle.
  always @(negedge clk) begin
    if (rst_ni0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        check("rdy0", rsp0.ready, 1'b1);
        check("data0", rsp0.data, q0[0].data);
        if (q0[0].rw) exp_wr0++; else exp_rd0++;
        void'(q0.pop_front());
      end else begin
        check("idle_rdy0", rsp0.ready, 1'b0);
        check("idle_data0", rsp0.data, '0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni1) begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        check("rdy1", rsp1.ready, 1'b1);
        check("data1", rsp1.data, q1[0].data);
        if (q1[0].rw) exp_wr1++; else exp_rd1++;
        void'(q1.pop_front());
      end else begin
        check("idle_rdy1", rsp1.ready, 1'b0);
        check("idle_data1", rsp1.data, '0);
      end
    end
  end

  // Called at a negedge: presents a one-cycle request, queues its expected
  // response, then scrambles addr/data to show they are not resampled.
  task automatic issue(input int inst, input bit rw, input logic [31:0] a, input logic [127:0] d);
    exp_t e;
    int   idx;
    idx  = int'(a[11:4]);
    e.rw = rw;
    if (inst == 0) begin
      req0 = '{addr: a, data: d, rw: rw, valid: 1'b1};
      e.cyc  = cyc + 1 + 4;
      e.data = rw ? '0 : model0[idx];
      if (rw) model0[idx] = d;
      q0.push_back(e);
    end else begin
      req1 = '{addr: a, data: d, rw: rw, valid: 1'b1};
      e.cyc  = cyc + 1 + 1;
      e.data = rw ? '0 : model1[idx];
      if (rw) model1[idx] = d;
      q1.push_back(e);
    end
    @(negedge clk);
    if (inst == 0) req0 = '{addr: ~a, data: ~d, rw: rw, valid: 1'b0};
    else           req1 = '{addr: ~a, data: ~d, rw: rw, valid: 1'b0};
  endtask

  task automatic drain(input int inst);
    int left;
    left = 1;
    for (int i = 0; i < 100; i++) begin
      left = (inst == 0) ? q0.size() : q1.size();
      if (left == 0) break;
      @(negedge clk);
    end
    check(inst == 0 ? "drain0" : "drain1", 128'(left), 128'd0);
    @(negedge clk);
  endtask

  task automatic check_cnt(input int inst);
    int er, ew;
`ifdef MEM_STATS_EN
    er = (inst == 0) ? exp_rd0 : exp_rd1;
    ew = (inst == 0) ? exp_wr0 : exp_wr1;
`else
    er = 0;
    ew = 0;
`endif
    if (inst == 0) begin
      check("no_rd0", no_rd0, 128'(er));
      check("no_wr0", no_wr0, 128'(ew));
    end else begin
      check("no_rd1", no_rd1, 128'(er));
      check("no_wr1", no_wr1, 128'(ew));
    end
  endtask

  initial begin
    logic [127:0] d, saved;
    logic [31:0]  a;
    int           rdcnt_before;
    req0 = '0;
    req1 = '0;
    rst_ni0 = 1'b0;
    rst_ni1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni0 = 1'b1;
    rst_ni1 = 1'b1;

    check("rst_busy0", busy0, 1'b0);
    check("rst_rdy0", rsp0.ready, 1'b0);
    check("rst_data0", rsp0.data, '0);
    check_cnt(0);

    // Write then read the same line.
    issue(0, 1'b1, 32'h0000_0040, {4{32'h1111_1111}});
    drain(0);
    issue(0, 1'b0, 32'h0000_0040, '0);
    drain(0);
    check_cnt(0);

    // Back to back: read request presented during the write's ready cycle.
    issue(0, 1'b1, 32'h0000_0080, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
    for (int i = 0; i < 4; i++) begin
      check("b2b_busy", busy0, 1'b1);
      @(negedge clk);
    end
    check("b2b_wr_rdy", rsp0.ready, 1'b1);
    issue(0, 1'b0, 32'h0000_0080, '0);
    for (int i = 0; i < 4; i++) begin
      check("b2b_busy", busy0, 1'b1);
      @(negedge clk);
    end
    drain(0);

    // A valid pulse while busy is dropped.
    rdcnt_before = exp_rd0;
    issue(0, 1'b0, 32'h0000_0040, '0);
    req0 = '{addr: 32'h0000_0080, data: '0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    req0.valid = 1'b0;
    drain(0);
    repeat (6) @(negedge clk);
    check("busy_pulse_rd", 128'(exp_rd0 - rdcnt_before), 128'd1);
    check_cnt(0);

    // Aliasing: 0x1010 and 0x0010 share line 1.
    issue(0, 1'b1, 32'h0000_1010, 128'hBEEF_CAFE_0000_0001_2222_3333_4444_5555);
    drain(0);
    issue(0, 1'b0, 32'h0000_0010, '0);
    drain(0);

    // Reset while a write is busy aborts it.
    issue(0, 1'b1, 32'h0000_0200, 128'hD);
    drain(0);
    saved = model0[32];
    issue(0, 1'b1, 32'h0000_0200, 128'hC0C0_C0C0);
    @(negedge clk);
    rst_ni0 = 1'b0;
    q0.delete();
    model0[32] = saved;
    exp_rd0 = 0;
    exp_wr0 = 0;
    @(negedge clk);
    rst_ni0 = 1'b1;
    check("abort_busy", busy0, 1'b0);
    check("abort_rdy", rsp0.ready, 1'b0);
    check_cnt(0);
    repeat (6) @(negedge clk);
    check_cnt(0);
    issue(0, 1'b0, 32'h0000_0200, '0);
    drain(0);

    // Random mix over eight lines, all written first.
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(0, 1'b1, 32'h0000_0300 + 32'(i * 16), d);
      drain(0);
    end
    for (int i = 0; i < 12; i++) begin
      a = 32'h0000_0300 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(0, 1'($urandom_range(0, 1)), a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drain(0);
    end
    check_cnt(0);

    // Single-cycle latency instance: ten transactions.
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(1, 1'b1, 32'(i * 16), d);
      drain(1);
    end
    for (int i = 0; i < 5; i++) begin
      issue(1, 1'b0, 32'(i * 16), '0);
      drain(1);
    end
    check_cnt(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
